riscv_alu_issue: RTL and testbench
==================================

# riscv_alu_issue

Decode-and-issue stage that drives the integer ALU. It accepts one instruction per cycle with its register-file operands and PC, and decodes OP, OP-IMM, LUI and AUIPC into ALU controls (`scr1`, `scr2`, `op`, `op_extend`). Results are registered into an output buffer with valid/ready handshakes on both sides, so the ALU/writeback stage can back-pressure the front end without losing instructions.

## Interface
- No parameters. Data width is fixed at 32 (RV32I).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: instruction and operands are valid.
- `in_ready` output 1: stage accepts the input this cycle.
- `in_instr` input 32: RV32I instruction word.
- `in_pc` input 32: PC of `in_instr`.
- `in_rs1_data` input 32: register-file value for `rs1`.
- `in_rs2_data` input 32: register-file value for `rs2`.
- `out_valid` output 1: issued entry is valid.
- `out_ready` input 1: ALU stage consumes the entry.
- `out_scr1` output 32: ALU operand 1.
- `out_scr2` output 32: ALU operand 2.
- `out_op` output 3: ALU function (funct3 encoding).
- `out_op_extend` output 1: SUB/SRA/SRAI select.
- `out_rd` output 5: destination register.
- `out_wb_en` output 1: writeback enable.
- `out_illegal` output 1: instruction not decodable by this stage.

## Operation
- Transfer: in = `in_valid && in_ready`; out = `out_valid && out_ready`.
- OP (0110011): `scr1`=rs1_data, `scr2`=rs2_data, `op`=funct3. funct7 must be 0000000, or 0100000 only with funct3 000 or 101; in the latter case `op_extend`=1.
- OP-IMM (0010011): `scr1`=rs1_data, `scr2`=sign-extended I-immediate, `op`=funct3, `op_extend`=0. For funct3 001: imm[11:5] must be 0. For funct3 101: imm[11:5] must be 0000000 or 0100000, `op_extend`=imm[10], and `scr2`=zero-extended shamt (imm[4:0]).
- LUI (0110111): `scr1`=0, `scr2`={instr[31:12],12'b0}, `op`=000, `op_extend`=0.
- AUIPC (0010111): `scr1`=in_pc, `scr2`=U-immediate, `op`=000, `op_extend`=0.
- Any other opcode or funct violation: `out_illegal`=1, `scr1`=`scr2`=0, `op`=000, `op_extend`=0, `wb_en`=0. The entry is still issued in order.
- `out_rd`=instr[11:7]; `out_wb_en`=legal && rd!=0.
- Buffer FSM (skid enabled): EMPTY -in-> ONE; ONE -in&!out-> TWO; ONE -out&!in-> EMPTY; ONE -in&out-> ONE; TWO -out-> ONE. The output always presents the oldest entry.
- `in_ready` = (state != TWO). It is registered, with no combinational path from `out_ready`.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing
- Latency 1 cycle: an entry accepted on edge N appears on `out_*` after edge N, with `out_valid`=1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, all data outputs 0 (`out_illegal`=0, `out_wb_en`=0).
- Reset asserted mid-operation discards all buffered entries immediately (asynchronously). The first accept can occur on the first edge after deassertion.
- Simultaneous in and out transfers in ONE: the new entry replaces the output, with no bubble.
- In TWO with `out_ready`=1: the skid entry moves to the output. `in_ready` rises for the next cycle.

## Configuration
- `RISCV_ALU_ISSUE_SKID_EN` defined: 2-entry skid buffer as above; `in_ready` is registered.
- Not defined: single output register only; `in_ready` = `!out_valid || out_ready` (combinational); state TWO does not exist. Decode and latency are unchanged.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: scr1=5, scr2=7, op=000, ext=0, rd=3, wb_en=1.
- SUB (0x402081B3) -> ext=1. SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> scr2=3, op=101, ext=1.
- ADDI x1,x0,-1 (0xFFF00093) -> scr2=0xFFFFFFFF, ext=0. LUI x1,0x12345 (0x123450B7) -> scr1=0, scr2=0x12345000. AUIPC with pc=0x100 -> scr1=0x100.
- Illegal cases: funct7=0100000 with funct3=100 (0x4020C1B3), and opcode 0x7F -> illegal=1, wb_en=0, operands 0, order preserved. ADD to rd=0 -> wb_en=0.
- Back-pressure (skid on): `out_ready`=0, three consecutive `in_valid` -> two accepted, `in_ready`=0 on the third. Release `out_ready` -> entries emerge in order with no loss or duplication. Skid off: `in_ready` follows `out_ready` in the same cycle.
- Assert `rst` for one cycle while in TWO -> `out_valid`=0 immediately, `in_ready`=1, and no stale entry appears after reset.

Source files
------------

// File: rtl/riscv_alu_issue.sv
// -----------------------------------------------------------------------------
// riscv_alu_issue
//
// Decode-and-issue stage in front of the RV32I integer ALU. Decodes OP, OP-IMM,
// LUI and AUIPC into ALU operand/function controls and hands the result to the
// ALU through a registered output buffer with valid/ready on both sides.
// Instructions this stage cannot decode are still issued in order, marked
// illegal, with zeroed operands and writeback disabled.
//
// Build option:
//   RISCV_ALU_ISSUE_SKID_EN  defined   : 2-entry skid buffer, in_ready registered
//                            undefined : single output register,
//                                        in_ready = !out_valid || out_ready
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      front-end handshake
//   in_instr, in_pc          instruction word and its PC
//   in_rs1_data, in_rs2_data register-file operands
//   out_valid / out_ready    ALU-side handshake
//   out_scr1, out_scr2       ALU operands
//   out_op, out_op_extend    ALU function (funct3) and SUB/SRA select
//   out_rd, out_wb_en        destination register and writeback enable
//   out_illegal              instruction not decodable by this stage
// -----------------------------------------------------------------------------
module riscv_alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_scr1,
    output logic [31:0] out_scr2,
    output logic [2:0]  out_op,
    output logic        out_op_extend,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] scr1;
        logic [31:0] scr2;
        logic [2:0]  op;
        logic        ext;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } entry_t;

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        legal;
    entry_t      dec;
    // rs1 index is resolved by the register file upstream; not needed here.
    logic [4:0]  unused_rs1_idx;

    assign opcode         = in_instr[6:0];
    assign f3             = in_instr[14:12];
    assign f7             = in_instr[31:25];
    assign imm_i          = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u          = {in_instr[31:12], 12'b0};
    assign unused_rs1_idx = in_instr[19:15];

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.rd = in_instr[11:7];
        // Operand/function fields are only filled on a legal decode, so an
        // illegal entry carries zero operands and op=000 automatically.
        case (opcode)
            OPC_OP: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    legal    = 1'b1;
                    dec.scr1 = in_rs1_data;
                    dec.scr2 = in_rs2_data;
                    dec.op   = f3;
                    dec.ext  = f7[5];
                end
            end
            OPC_IMM: begin
                case (f3)
                    3'b001: begin
                        if (f7 == 7'b0000000) begin
                            legal    = 1'b1;
                            dec.scr1 = in_rs1_data;
                            dec.scr2 = imm_i;
                            dec.op   = f3;
                        end
                    end
                    3'b101: begin
                        // Shift-right immediates: imm[10] selects arithmetic,
                        // the operand is only the 5-bit shamt.
                        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                            legal    = 1'b1;
                            dec.scr1 = in_rs1_data;
                            dec.scr2 = {27'b0, in_instr[24:20]};
                            dec.op   = f3;
                            dec.ext  = in_instr[30];
                        end
                    end
                    default: begin
                        legal    = 1'b1;
                        dec.scr1 = in_rs1_data;
                        dec.scr2 = imm_i;
                        dec.op   = f3;
                    end
                endcase
            end
            OPC_LUI: begin
                legal    = 1'b1;
                dec.scr2 = imm_u;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                dec.scr1 = in_pc;
                dec.scr2 = imm_u;
            end
            default: legal = 1'b0;
        endcase
        dec.illegal = !legal;
        dec.wb_en   = legal && (in_instr[11:7] != 5'd0);
    end

    // ---------------------------------------------------------------------
    // Output buffer
    // ---------------------------------------------------------------------
    entry_t out_q, out_d;
    logic   in_fire;
    logic   out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef RISCV_ALU_ISSUE_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t state_q, state_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    // in_ready is computed from the next state so it never depends
    // combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    out_d   = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    out_d = dec;
                end else if (in_fire) begin
                    skid_d  = dec;
                    state_d = S_TWO;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only the drain path is possible.
                if (out_fire) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
`else
    typedef enum logic {S_EMPTY, S_ONE} state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    out_d   = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire) begin
                    out_d = dec;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign in_ready  = !out_valid || out_ready;
    assign out_valid = (state_q != S_EMPTY);
`endif

    assign out_scr1      = out_q.scr1;
    assign out_scr2      = out_q.scr2;
    assign out_op        = out_q.op;
    assign out_op_extend = out_q.ext;
    assign out_rd        = out_q.rd;
    assign out_wb_en     = out_q.wb_en;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_issue
//
// Table-driven bench for riscv_alu_issue. Each accepted instruction pushes its
// expected issue record to a scoreboard queue; each output transfer pops and
// compares. Hand sequences cover latency, back-pressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_riscv_alu_issue;

    typedef struct packed {
        logic [31:0] scr1;
        logic [31:0] scr2;
        logic [2:0]  op;
        logic        ext;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        ent_t        exp;
    } vec_t;

    localparam int NVEC = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_scr1;
    logic [31:0] out_scr2;
    logic [2:0]  out_op;
    logic        out_op_extend;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;

    riscv_alu_issue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_scr1     (out_scr1),
        .out_scr2     (out_scr2),
        .out_op       (out_op),
        .out_op_extend(out_op_extend),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    vec_t vecs [NVEC];
    ent_t sb [$];
    ent_t exp_cur;
    ent_t cur;
    ent_t held;
    logic stall_prev = 1'b0;
    logic rand_rdy   = 1'b0;
    int   tests = 0;
    int   fails = 0;

    assign cur = '{scr1: out_scr1, scr2: out_scr2, op: out_op, ext: out_op_extend,
                   rd: out_rd, wb: out_wb_en, ill: out_illegal};

    function automatic ent_t mk(input logic [31:0] s1, input logic [31:0] s2,
                                input logic [2:0] op, input logic ext,
                                input logic [4:0] rd, input logic wb, input logic ill);
        mk = '{scr1: s1, scr2: s2, op: op, ext: ext, rd: rd, wb: wb, ill: ill};
    endfunction

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare each output transfer against the scoreboard, check hold
    // stability under stall, and record each input transfer.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                tests++;
                if (cur !== held) begin
                    fails++;
                    $display("FAIL hold_stable actual=%h required=%h", cur, held);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out actual=%h required=none", cur);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL issue_entry actual=%h required=%h", cur, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
            stall_prev = out_valid && !out_ready;
            held       = cur;
        end
    end

    // Random output back-pressure when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic present(input int idx);
        in_instr    = vecs[idx].instr;
        in_pc       = vecs[idx].pc;
        in_rs1_data = vecs[idx].rs1;
        in_rs2_data = vecs[idx].rs2;
        exp_cur     = vecs[idx].exp;
        in_valid    = 1'b1;
    endtask

    // Present a vector and hold it until accepted; returns at posedge+1.
    // in_valid stays high, so the caller must present the next item or drop it.
    task automatic send(input int idx);
        int n;
        present(idx);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout actual=in_ready0 required=in_ready1 idx=%0d", idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 75'(sb.size()), 75'd0);
    endtask

    initial begin
        // {instr, pc, rs1, rs2, expected}
        vecs[0]  = '{32'h002081B3, 32'h0, 32'd5,        32'd7,      mk(32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0)};
        vecs[1]  = '{32'h402081B3, 32'h0, 32'd10,       32'd3,      mk(32'd10, 32'd3, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0)};
        vecs[2]  = '{32'h40335293, 32'h0, 32'h80000000, 32'h1234,   mk(32'h80000000, 32'd3, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0)};
        vecs[3]  = '{32'hFFF00093, 32'h0, 32'h0,        32'h55,     mk(32'h0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0)};
        vecs[4]  = '{32'h123450B7, 32'h40, 32'hDEAD,    32'hBEEF,   mk(32'h0, 32'h12345000, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0)};
        vecs[5]  = '{32'h00001117, 32'h100, 32'h77,     32'h88,     mk(32'h100, 32'h1000, 3'b000, 1'b0, 5'd2, 1'b1, 1'b0)};
        vecs[6]  = '{32'h4020C1B3, 32'h0, 32'h11,       32'h22,     mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1)};
        vecs[7]  = '{32'h0000027F, 32'h200, 32'h33,     32'h44,     mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd4, 1'b0, 1'b1)};
        vecs[8]  = '{32'h00208033, 32'h0, 32'd1,        32'd2,      mk(32'd1, 32'd2, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0)};
        vecs[9]  = '{32'h01F41393, 32'h0, 32'd1,        32'd9,      mk(32'd1, 32'd31, 3'b001, 1'b0, 5'd7, 1'b1, 1'b0)};
        vecs[10] = '{32'h41F41393, 32'h0, 32'd1,        32'd9,      mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd7, 1'b0, 1'b1)};
        vecs[11] = '{32'h0020D1B3, 32'h0, 32'hF0,       32'd4,      mk(32'hF0, 32'd4, 3'b101, 1'b0, 5'd3, 1'b1, 1'b0)};
        vecs[12] = '{32'h7FF0C493, 32'h0, 32'hAAAA,     32'h0,      mk(32'hAAAA, 32'h7FF, 3'b100, 1'b0, 5'd9, 1'b1, 1'b0)};
        vecs[13] = '{32'h022081B3, 32'h0, 32'd6,        32'd7,      mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1)};
        vecs[14] = '{32'h4020D1B3, 32'h0, 32'h80000000, 32'd31,     mk(32'h80000000, 32'd31, 3'b101, 1'b1, 5'd3, 1'b1, 1'b0)};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        out_ready   = 1'b0;
        exp_cur     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 75'(out_valid), 75'd0);
        check("rst_in_ready", 75'(in_ready), 75'd1);
        check("rst_data", cur, 75'd0);
        rst = 1'b0;

        // One-cycle latency: accepted entry is on the outputs right after the edge
        send(0);
        in_valid = 1'b0;
        check("latency_valid", 75'(out_valid), 75'd1);
        check("latency_data", cur, vecs[0].exp);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Full table at full throughput
        for (int i = 0; i < NVEC; i++) send(i);
        in_valid = 1'b0;
        drain();

        // Full table under random back-pressure
        rand_rdy = 1'b1;
        for (int i = NVEC - 1; i >= 0; i--) send(i);
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Back-pressure sequence
        out_ready = 1'b0;
        #1;
        check("stall_empty_ready", 75'(in_ready), 75'd1);
        send(0);
`ifdef RISCV_ALU_ISSUE_SKID_EN
        send(1);
        present(2);
        @(negedge clk);
        check("bp_third_blocked", 75'(in_ready), 75'd0);
        check("bp_oldest_out", cur, vecs[0].exp);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_ready_registered", 75'(in_ready), 75'd0);
        send(2);
`else
        present(1);
        @(negedge clk);
        check("bp_second_blocked", 75'(in_ready), 75'd0);
        check("bp_oldest_out", cur, vecs[0].exp);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_ready_follows", 75'(in_ready), 75'd1);
        send(1);
`endif
        in_valid = 1'b0;
        drain();

        // Reset while the buffer is full
        out_ready = 1'b0;
        send(3);
`ifdef RISCV_ALU_ISSUE_SKID_EN
        send(4);
`endif
        in_valid = 1'b0;
        #1;
        check("full_before_rst", 75'(out_valid), 75'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 75'(out_valid), 75'd0);
        check("rst_async_ready", 75'(in_ready), 75'd1);
        check("rst_async_data", cur, 75'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(5);
        in_valid = 1'b0;
        check("post_rst_first_valid", 75'(out_valid), 75'd1);
        check("post_rst_first_data", cur, vecs[5].exp);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_after_rst", 75'(out_valid), 75'd0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
